apb_stdout_stream: RTL and testbench
====================================

APB_STDOUT_STREAM -- requirements
Module: apb_stdout_stream

Interface
REQ-001 Parameter N_CORES, default 8, cores per cluster (1..16).
REQ-002 Parameter N_CLUSTERS, default 1, clusters (1..16); channel count NCH = N_CLUSTERS*N_CORES.
REQ-003 Parameter ADDR_WIDTH, default 32, APB address width (>=12).
REQ-004 Parameter DATA_WIDTH, default 32, APB data width (fixed 32).
REQ-005 Parameter DEPTH, default 64, entries per channel FIFO (power of 2, >=2).
REQ-006 clk_i  input  1  clock, rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 apb  APB_BUS.Slave  --  register access port; pready=1 always.
REQ-009 m_valid_o  output  1  stream byte valid.
REQ-010 m_ready_i  input  1  stream sink ready.
REQ-011 m_data_o  output  8  stream byte.
REQ-012 m_chan_o  output  $clog2(NCH) (min 1)  source channel of byte.
REQ-013 m_last_o  output  1  byte ends a line.

Function
REQ-014 An APB access is an access-phase cycle (psel & penable); channel ch = paddr[10:7]*N_CORES + paddr[6:3] when paddr[11]=0.
REQ-015 Data-window write with paddr[10:7] < N_CLUSTERS and paddr[6:3] < N_CORES shall push {eol, pwdata[7:0]} into FIFO ch; eol=1 if byte is 8'h0A, or if the push makes the FIFO full (forced line end).
REQ-016 Data-window write to a full FIFO shall drop the byte and increment the 16-bit saturating overflow counter.
REQ-017 Data-window access to an out-of-range cluster/core shall assert pslverr and have no effect; all other accesses keep pslverr=0.
REQ-018 Data-window read returns FIFO ch fill level, zero-extended.
REQ-019 Offset 0x800 read returns the overflow counter; any write clears it; a same-cycle clear and overflow leaves it at 1.
REQ-020 Offset 0x804 read returns the line-pending bitmap, bit i = channel i holds >=1 eol entry (channels 0..31); writes ignored; other status offsets read 0.
REQ-021 Per channel, a line counter (width $clog2(DEPTH)+1) increments on eol push and decrements on eol pop; simultaneous push and pop of the same channel keep fill level and net the counter.
REQ-022 Drain FSM states IDLE and STREAM; IDLE: if any line counter >0, register grant to the first pending channel after the last granted (round-robin, wrapping NCH-1 to 0), go STREAM.
REQ-023 STREAM: m_valid_o=1, m_data_o/m_chan_o/m_last_o from head of granted FIFO (m_last_o = entry eol); on m_valid_o & m_ready_i pop head; pop of eol entry returns to IDLE.
REQ-024 Grant is locked until its eol byte transfers; bytes of different lines never interleave.
REQ-025 Latency: eol write in access cycle T -> m_valid_o high at T+2 when FSM idle.
REQ-026 m_data_o, m_chan_o, m_last_o stable while m_valid_o & !m_ready_i.

Reset
REQ-027 Reset shall empty all FIFOs, zero line counters, overflow counter, and round-robin pointer (first grant searches from channel 0), force FSM to IDLE.
REQ-028 Reset values: m_valid_o=0, m_data_o=0, m_chan_o=0, m_last_o=0, prdata=0, pslverr=0, pready=1.
REQ-029 Reset mid-line discards the partial line; no byte of it appears after reset.

Configuration
REQ-030 With APB_STDOUT_STREAM_SIM_PRINT_EN defined, each transferred line shall be printed by the simulator as "[cl,core] text" at its m_last_o handshake (newline byte excluded); without it, no simulation-only code is compiled and behaviour is otherwise identical.

Structure
REQ-031 Package apb_stdout_stream_pkg holds the entry typedef {eol, byte}, status offsets 0x800/0x804, newline constant 8'h0A, and the FSM state enum.
REQ-032 One sub-module stdout_chan_fifo (DEPTH-entry FIFO with fill level and line counter), instantiated NCH times.

Verification
REQ-033 Write "Hi\n" to cl0/core1, m_ready_i=1 -> bytes 48,69,0A on chan 1, m_last_o only on 0A, first valid 2 cycles after 0A write.
REQ-034 Lines pending on chans 0 and 3, last grant 0 -> chan 3 line fully drained before chan 0; no interleave with m_ready_i toggling.
REQ-035 DEPTH=4, write 6 non-newline bytes to chan 0 -> 4th byte has m_last_o=1, overflow counter reads 2 at 0x800; write 0x800 -> reads 0.
REQ-036 Access cluster 15 with N_CLUSTERS=1 -> pslverr=1, no FIFO change, bitmap 0x804 unchanged.
REQ-037 Assert rst_ni low mid-stream of "abc\n" after 'a' transferred -> m_valid_o=0, bitmap 0, no further bytes after release.
REQ-038 Stall m_ready_i=0 while writing same channel each cycle -> fill level via read correct, output fields stable.

Source files
------------

// File: rtl/apb_stdout_stream_pkg.sv
// rtl/apb_stdout_stream_pkg.sv - shared types and constants for the APB stdout stream block
package apb_stdout_stream_pkg;

  typedef struct packed {
    logic       eol;
    logic [7:0] data;
  } entry_t;

  localparam logic [11:0] STATUS_OVF_OFFS   = 12'h800;
  localparam logic [11:0] STATUS_LINES_OFFS = 12'h804;
  localparam logic [7:0]  NEWLINE           = 8'h0A;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_e;

  function automatic int chan_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/apb_bus.sv
// rtl/apb_bus.sv - APB bus interface with master and slave views
interface APB_BUS #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/stdout_chan_fifo.sv
// rtl/stdout_chan_fifo.sv - per-channel byte FIFO tracking fill level and complete lines held
module stdout_chan_fifo
  import apb_stdout_stream_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [7:0]            data_i,
  input  logic                  pop_i,
  output entry_t                head_o,
  output logic                  full_o,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic [$clog2(DEPTH):0] lines_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  entry_t        mem_q [DEPTH];
  entry_t        wentry;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   fill_q, fill_d, lines_q, lines_d;

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (fill_q == LVL_FULL);
  assign fill_o  = fill_q;
  assign lines_o = lines_q;

  always_comb begin
    wentry.data = data_i;
    // A push that fills the FIFO closes the line so the drain can always make progress.
    wentry.eol  = (data_i == NEWLINE) || ((fill_q == LVL_LAST) && !pop_i);
    wptr_d      = push_i ? wptr_q + AW'(1) : wptr_q;
    rptr_d      = pop_i ? rptr_q + AW'(1) : rptr_q;
    fill_d      = fill_q;
    lines_d     = lines_q;
    if (push_i && !pop_i) begin
      fill_d = fill_q + ONE;
    end else if (pop_i && !push_i) begin
      fill_d = fill_q - ONE;
    end
    if (push_i && wentry.eol) begin
      lines_d = lines_d + ONE;
    end
    if (pop_i && head_o.eol) begin
      lines_d = lines_d - ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      lines_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      lines_q <= lines_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= wentry;
    end
  end

endmodule

// File: rtl/apb_stdout_stream.sv
// rtl/apb_stdout_stream.sv - APB-written per-core stdout FIFOs drained line by line onto a byte stream
// Optional: define APB_STDOUT_STREAM_SIM_PRINT_EN to print each transferred line in simulation.
module apb_stdout_stream
  import apb_stdout_stream_pkg::*;
#(
  parameter int N_CORES    = 8,
  parameter int N_CLUSTERS = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  APB_BUS.Slave                                       apb,
  output logic                                        m_valid_o,
  input  logic                                        m_ready_i,
  output logic [7:0]                                  m_data_o,
  output logic [chan_width(N_CLUSTERS*N_CORES)-1:0]   m_chan_o,
  output logic                                        m_last_o
);

  localparam int NCH = N_CLUSTERS * N_CORES;
  localparam int CHW = chan_width(NCH);
  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int NBM = (NCH < 32) ? NCH : 32;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  unused_bits;

  assign paddr       = apb.paddr;
  assign pwdata      = apb.pwdata;
  assign unused_bits = ^{paddr[ADDR_WIDTH-1:12], pwdata[DATA_WIDTH-1:8]};

  logic            acc, in_range, data_wr, ovf_inc, ovf_clr;
  logic [3:0]      cl_idx, core_idx;
  logic [CHW-1:0]  ch;
  entry_t          heads [NCH];
  logic [LW-1:0]   fill  [NCH];
  logic [LW-1:0]   lines [NCH];
  logic [NCH-1:0]  full, push, pop, line_nz;
  logic [31:0]     bitmap;
  logic [DATA_WIDTH-1:0] prdata;
  logic            slverr;

  state_e          state_q, state_d;
  logic [CHW-1:0]  grant_q, grant_d, rr_q, rr_d, pick;
  logic            found;
  logic [15:0]     ovf_q, ovf_d;
  entry_t          head;

  always_comb begin
    acc      = apb.psel & apb.penable;
    cl_idx   = paddr[10:7];
    core_idx = paddr[6:3];
    in_range = (int'(cl_idx) < N_CLUSTERS) && (int'(core_idx) < N_CORES);
    ch       = CHW'(int'(cl_idx) * N_CORES + int'(core_idx));
    data_wr  = acc && apb.pwrite && !paddr[11] && in_range;
    ovf_inc  = data_wr && full[ch];
    ovf_clr  = acc && apb.pwrite && (paddr[11:0] == STATUS_OVF_OFFS);
    for (int i = 0; i < NCH; i++) begin
      push[i]    = data_wr && (ch == CHW'(i)) && !full[i];
      pop[i]     = (state_q == ST_STREAM) && m_ready_i && (grant_q == CHW'(i));
      line_nz[i] = (lines[i] != '0);
    end
    bitmap = '0;
    for (int i = 0; i < NBM; i++) begin
      bitmap[i] = line_nz[i];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    stdout_chan_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push[g]),
      .data_i  (pwdata[7:0]),
      .pop_i   (pop[g]),
      .head_o  (heads[g]),
      .full_o  (full[g]),
      .fill_o  (fill[g]),
      .lines_o (lines[g])
    );
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = ovf_inc ? 16'd1 : 16'd0;
    end else if (ovf_inc && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_comb begin
    prdata = '0;
    slverr = 1'b0;
    if (acc) begin
      if (!paddr[11]) begin
        if (!in_range) begin
          slverr = 1'b1;
        end else if (!apb.pwrite) begin
          prdata = DATA_WIDTH'(fill[ch]);
        end
      end else if (!apb.pwrite) begin
        case (paddr[11:0])
          STATUS_OVF_OFFS:   prdata = DATA_WIDTH'(ovf_q);
          STATUS_LINES_OFFS: prdata = DATA_WIDTH'(bitmap);
          default:           prdata = '0;
        endcase
      end
    end
  end

  assign apb.prdata  = prdata;
  assign apb.pslverr = slverr;
  assign apb.pready  = 1'b1;

  // Round-robin search starts at rr_q, which always points one past the last grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    found   = 1'b0;
    pick    = rr_q;
    head    = heads[grant_q];
    for (int k = 0; k < NCH; k++) begin
      if (!found && line_nz[(int'(rr_q) + k) % NCH]) begin
        found = 1'b1;
        pick  = CHW'((int'(rr_q) + k) % NCH);
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = pick;
          rr_d    = (int'(pick) == NCH - 1) ? '0 : pick + CHW'(1);
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (m_ready_i && head.eol) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign m_valid_o = (state_q == ST_STREAM);
  assign m_data_o  = m_valid_o ? head.data : 8'h00;
  assign m_last_o  = m_valid_o & head.eol;
  assign m_chan_o  = m_valid_o ? grant_q : '0;

`ifdef APB_STDOUT_STREAM_SIM_PRINT_EN
  string line_q;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= "";
    end else if (m_valid_o && m_ready_i) begin
      if (m_last_o) begin
        if (m_data_o == NEWLINE) begin
          $display("[%0d,%0d] %s", grant_q / N_CORES, grant_q % N_CORES, line_q);
        end else begin
          $display("[%0d,%0d] %s%c", grant_q / N_CORES, grant_q % N_CORES, line_q, m_data_o);
        end
        line_q <= "";
      end else begin
        line_q <= {line_q, $sformatf("%c", m_data_o)};
      end
    end
  end
`endif

endmodule

// File: tb/tb_apb_stdout_stream.sv
// tb/tb_apb_stdout_stream.sv - directed self-checking bench for apb_stdout_stream (DEPTH=4, 8 channels)
module tb_apb_stdout_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic [2:0] m_chan;
  logic       m_last;

  always #5 clk = ~clk;

  APB_BUS #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) apb_if ();

  apb_stdout_stream #(
    .N_CORES    (8),
    .N_CLUSTERS (1),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .apb       (apb_if),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_chan_o  (m_chan),
    .m_last_o  (m_last)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        vt [8];
  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] mon_q [$];
  logic [11:0] exp_q [$];
  logic [31:0] rd;
  logic        err;

  // Handshakes are recorded mid-cycle; the transfer itself happens on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) mon_q.push_back({m_chan, m_last, m_data});
  end

  function automatic logic [11:0] pk(input int ch, input logic last, input logic [7:0] d);
    return {3'(ch), last, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic perr);
    @(posedge clk); #1;
    apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = wr;
    apb_if.paddr = addr; apb_if.pwdata = wdata;
    @(posedge clk); #1;
    apb_if.penable = 1'b1;
    @(negedge clk);
    rdata = apb_if.prdata;
    perr  = apb_if.pslverr;
    @(posedge clk); #1;
    apb_if.psel = 1'b0; apb_if.penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    logic [31:0] r;
    logic        e;
    apb_xfer(1'b1, a, 32'(d), r, e);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    apb_xfer(1'b0, a, 32'h0, r, e);
    chk(name, r, exp);
  endtask

  task automatic ex(input int ch, input logic last, input logic [7:0] d);
    exp_q.push_back(pk(ch, last, d));
  endtask

  task automatic chk_stream(input string name);
    int budget = 300;
    while (mon_q.size() < exp_q.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({name, "_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      chk($sformatf("%s_byte%0d", name, i),
          (i < mon_q.size()) ? 32'(mon_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  task automatic chk_head(input string name, input logic [7:0] d, input logic [2:0] c);
    chk({name, "_valid"}, 32'(m_valid), 32'd1);
    chk({name, "_data"}, 32'(m_data), 32'(d));
    chk({name, "_chan"}, 32'(m_chan), 32'(c));
    chk({name, "_last"}, 32'(m_last), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ovl_addr [5];
    logic [7:0]  ovl_data [5];

    vt[0] = '{1'b1, 32'h780, 32'h0A, 32'h0, 1'b1};
    vt[1] = '{1'b0, 32'h780, 32'h0,  32'h0, 1'b1};
    vt[2] = '{1'b1, 32'h040, 32'h41, 32'h0, 1'b1};
    vt[3] = '{1'b0, 32'h004, 32'h0,  32'h0, 1'b0};
    vt[4] = '{1'b0, 32'h804, 32'h0,  32'h0, 1'b0};
    vt[5] = '{1'b1, 32'h804, 32'hFF, 32'h0, 1'b0};
    vt[6] = '{1'b0, 32'h808, 32'h0,  32'h0, 1'b0};
    vt[7] = '{1'b0, 32'h800, 32'h0,  32'h0, 1'b0};

    rst_n = 1'b0; m_ready = 1'b0;
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    apb_if.paddr = '0; apb_if.pwdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_chan", 32'(m_chan), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_prdata", apb_if.prdata, 32'd0);
    chk("rst_pslverr", 32'(apb_if.pslverr), 32'd0);
    chk("rst_pready", 32'(apb_if.pready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apb_xfer(vt[i].wr, vt[i].addr, vt[i].wdata, rd, err);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vt[i].exp_err));
    end

    // "Hi\n" on cluster 0 core 1 with latency check
    m_ready = 1'b1; mon_q.delete();
    wr(32'h08, 8'h48); wr(32'h08, 8'h69); wr(32'h08, 8'h0A);
    @(negedge clk); chk("lat_t1_valid", 32'(m_valid), 32'd0);
    @(negedge clk); chk("lat_t2_valid", 32'(m_valid), 32'd1);
    ex(1, 0, 8'h48); ex(1, 0, 8'h69); ex(1, 1, 8'h0A);
    chk_stream("hi");

    // Grant locked on chan 0 while chans 0 and 3 complete further lines
    m_ready = 1'b0; mon_q.delete();
    wr(32'h00, 8'h41); wr(32'h00, 8'h0A);
    repeat (2) @(negedge clk);
    ovl_addr = '{32'h18, 32'h18, 32'h00, 32'h00, 32'h18};
    ovl_data = '{8'h70, 8'h71, 8'h42, 8'h0A, 8'h0A};
    for (int i = 0; i < 5; i++) begin
      wr(ovl_addr[i], ovl_data[i]);
      chk_head($sformatf("rr_hold%0d", i), 8'h41, 3'd0);
    end
    rd_chk("rr_bitmap", 32'h804, 32'h09);
    for (int b = 0; b < 100 && mon_q.size() < 7; b++) begin
      @(posedge clk); #1;
      m_ready = ~m_ready;
    end
    m_ready = 1'b0;
    ex(0, 0, 8'h41); ex(0, 1, 8'h0A);
    ex(3, 0, 8'h70); ex(3, 0, 8'h71); ex(3, 1, 8'h0A);
    ex(0, 0, 8'h42); ex(0, 1, 8'h0A);
    chk_stream("rr");

    // Forced line end and overflow counting on a full FIFO
    m_ready = 1'b0; mon_q.delete();
    for (int i = 1; i <= 6; i++) wr(32'h00, 8'(8'h30 + i));
    rd_chk("ovf_count", 32'h800, 32'd2);
    rd_chk("ovf_fill", 32'h000, 32'd4);
    wr(32'h800, 8'h5A);
    rd_chk("ovf_clear", 32'h800, 32'd0);
    m_ready = 1'b1;
    ex(0, 0, 8'h31); ex(0, 0, 8'h32); ex(0, 0, 8'h33); ex(0, 1, 8'h34);
    chk_stream("full");
    m_ready = 1'b0;

    // Stalled sink while the same channel keeps filling
    mon_q.delete();
    wr(32'h10, 8'h7A); wr(32'h10, 8'h0A);
    repeat (2) @(negedge clk);
    wr(32'h10, 8'h61);
    rd_chk("stall_fill3", 32'h10, 32'd3);
    chk_head("stall_a", 8'h7A, 3'd2);
    wr(32'h10, 8'h62);
    rd_chk("stall_fill4", 32'h10, 32'd4);
    chk_head("stall_b", 8'h7A, 3'd2);
    m_ready = 1'b1;
    ex(2, 0, 8'h7A); ex(2, 1, 8'h0A); ex(2, 0, 8'h61); ex(2, 1, 8'h62);
    chk_stream("stall");
    m_ready = 1'b0;

    // Reset in the middle of "abc\n" after 'a' has transferred
    mon_q.delete();
    wr(32'h20, 8'h61); wr(32'h20, 8'h62); wr(32'h20, 8'h63); wr(32'h20, 8'h0A);
    repeat (2) @(negedge clk);
    chk_head("mid_a", 8'h61, 3'd4);
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
    @(negedge clk);
    chk("mid_b_data", 32'(m_data), 32'h62);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_valid", 32'(m_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; m_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_count", 32'(mon_q.size()), 32'd1);
    chk("mid_first", (mon_q.size() > 0) ? 32'(mon_q[0]) : 32'hDEAD, 32'(pk(4, 0, 8'h61)));
    rd_chk("mid_bitmap", 32'h804, 32'd0);
    rd_chk("mid_fill", 32'h20, 32'd0);
    chk("mid_after_count", 32'(mon_q.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
